// File: rtl/lbm_pkg.sv
// Shared types for the lattice-Boltzmann ping-pong bank controller.
// Holds the sample type, its default width and the skid-buffer state encoding.
package lbm_pkg;

    localparam int LBM_DATA_WIDTH = 64;

    typedef logic signed [LBM_DATA_WIDTH-1:0] dist_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        FULL = 2'd2
    } buf_state_t;

endpackage

// File: rtl/lbm_skid_buf.sv
// Two-entry skid buffer with a registered in_ready and 1-cycle latency.
// The head entry drives out_data directly; the skid entry absorbs one extra sample.
module lbm_skid_buf
    import lbm_pkg::*;
#(
    parameter int DATA_WIDTH = LBM_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data
);

    buf_state_t state;
    buf_state_t state_nxt;

    logic signed [DATA_WIDTH-1:0] skid;

    logic push;
    logic pop;
    logic load_head;
    logic load_skid;
    logic head_from_skid;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (state != IDLE);

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next occupancy and which register loads on this push/pop combination
    always_comb begin
        state_nxt      = state;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        unique case (state)
            IDLE: begin
                if (push) begin
                    load_head = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (pop) begin
                    state_nxt = IDLE;
                end
            end
            FULL: begin
                if (pop) begin
                    head_from_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // in_ready is registered from the next occupancy; held low in reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (state_nxt != FULL);
        end
    end

    // Head and skid data registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data <= '0;
            skid     <= '0;
        end else begin
            if (load_head) begin
                out_data <= in_data;
            end else if (head_from_skid) begin
                out_data <= skid;
            end
            if (load_skid) begin
                skid <= in_data;
            end
        end
    end

endmodule

// File: rtl/lbm_pingpong_ctrl.sv
// Ping-pong bank controller: streams samples through a skid buffer and flips
// the bank select after every NUM_NODES outputs. Option: PINGPONG_STALL_CNT_EN.
module lbm_pingpong_ctrl
    import lbm_pkg::*;
#(
    parameter int DATA_WIDTH = LBM_DATA_WIDTH,
    parameter int NUM_NODES  = 16,
    parameter int STEP_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         select,
    output logic [STEP_WIDTH-1:0]        step_count,
    output logic                         sweep_done
`ifdef PINGPONG_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_count
`endif
);

    localparam int IDX_W = (NUM_NODES > 2) ? $clog2(NUM_NODES) : 1;

    logic [IDX_W-1:0] node_idx;
    logic             pop;
    logic             last;

    lbm_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign pop  = out_valid && out_ready;
    assign last = (node_idx == IDX_W'(NUM_NODES - 1));

    // Node position, bank select and sweep counter advance on output transfers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            node_idx   <= '0;
            select     <= 1'b0;
            step_count <= '0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= pop && last;
            if (pop) begin
                if (last) begin
                    node_idx   <= '0;
                    select     <= ~select;
                    step_count <= step_count + STEP_WIDTH'(1);
                end else begin
                    node_idx <= node_idx + IDX_W'(1);
                end
            end
        end
    end

`ifdef PINGPONG_STALL_CNT_EN
    // Saturating count of cycles where downstream withholds ready
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
